// File: rtl/axi_wr_path.sv
// AXI4 INCR write-path front end: buffers AW/W, issues one store per complete burst, returns B in order.
// Optional burst-length check enabled by defining AXI_WR_PATH_LEN_CHECK_EN.
module axi_wr_path_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock)
    if (push) mem[wp[AW-1:0]] <= din;

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  // extra pointer bit distinguishes full from empty
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module axi_wr_path #(
  parameter int ADDRS           = 32,
  parameter int WIDTH           = 32,
  parameter int MASKS           = WIDTH/8,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int CTRL_FIFO_DEPTH = 16,
  parameter int DATA_FIFO_DEPTH = 512
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [ADDRS-1:0]        axi_awaddr_i,
  input  logic [AXI_ID_WIDTH-1:0] axi_awid_i,
  input  logic [7:0]              axi_awlen_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  input  logic                    axi_wlast_i,
  input  logic [MASKS-1:0]        axi_wstrb_i,
  input  logic [WIDTH-1:0]        axi_wdata_i,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  output logic [1:0]              axi_bresp_o,
  output logic [AXI_ID_WIDTH-1:0] axi_bid_o,
  output logic                    mem_store_o,
  input  logic                    mem_accept_i,
  output logic [AXI_ID_WIDTH-1:0] mem_wrid_o,
  output logic [ADDRS-1:0]        mem_addr_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic                    mem_last_o,
  output logic [MASKS-1:0]        mem_strb_o,
  output logic [WIDTH-1:0]        mem_data_o
);
  localparam int PW = $clog2(DATA_FIFO_DEPTH) + 1;
`ifdef AXI_WR_PATH_LEN_CHECK_EN
  localparam int CW = ADDRS + AXI_ID_WIDTH + 8;
`else
  localparam int CW = ADDRS + AXI_ID_WIDTH;
`endif
  localparam int DW = 1 + MASKS + WIDTH;
  localparam int RW = AXI_ID_WIDTH + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_STORE, ST_XFER, ST_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    ready_en;
  logic [PW-1:0]           pkt_cnt;
  logic [AXI_ID_WIDTH-1:0] cur_id;
  logic [1:0]              cur_resp;

  logic          cmd_full, cmd_empty, dat_full, dat_empty, rsp_full, rsp_empty;
  logic [CW-1:0] cmd_din, cmd_dout;
  logic [DW-1:0] dat_dout;
  logic [RW-1:0] rsp_dout;
  logic          aw_hs, w_last_hs, mem_hs, last_hs, rsp_push;

  // readies come up one cycle after the first non-reset edge
  always_ff @(posedge clock)
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;

  assign axi_awready_o = ready_en & ~cmd_full;
  assign axi_wready_o  = ready_en & ~dat_full;
  assign aw_hs         = axi_awvalid_i & axi_awready_o;
  assign w_last_hs     = axi_wvalid_i & axi_wready_o & axi_wlast_i;

`ifdef AXI_WR_PATH_LEN_CHECK_EN
  logic [7:0] cmd_len;
  logic [8:0] beat;
  assign cmd_din = {axi_awaddr_i, axi_awid_i, axi_awlen_i};
  assign {mem_addr_o, mem_wrid_o, cmd_len} = cmd_dout;
`else
  logic unused_len;
  assign unused_len = ^axi_awlen_i;
  assign cmd_din = {axi_awaddr_i, axi_awid_i};
  assign {mem_addr_o, mem_wrid_o} = cmd_dout;
`endif

  axi_wr_path_fifo #(.W(CW), .DEPTH(CTRL_FIFO_DEPTH)) u_cmd (
    .clock(clock), .reset(reset), .push(aw_hs), .din(cmd_din), .pop(last_hs),
    .dout(cmd_dout), .empty(cmd_empty), .full(cmd_full));

  axi_wr_path_fifo #(.W(DW), .DEPTH(DATA_FIFO_DEPTH)) u_dat (
    .clock(clock), .reset(reset), .push(axi_wvalid_i & axi_wready_o),
    .din({axi_wlast_i, axi_wstrb_i, axi_wdata_i}), .pop(mem_hs),
    .dout(dat_dout), .empty(dat_empty), .full(dat_full));

  axi_wr_path_fifo #(.W(RW), .DEPTH(CTRL_FIFO_DEPTH)) u_rsp (
    .clock(clock), .reset(reset), .push(rsp_push), .din({cur_id, cur_resp}),
    .pop(axi_bvalid_o & axi_bready_i), .dout(rsp_dout), .empty(rsp_empty), .full(rsp_full));

  assign {mem_last_o, mem_strb_o, mem_data_o} = dat_dout;
  assign {axi_bid_o, axi_bresp_o}             = rsp_dout;
  assign axi_bvalid_o = ~rsp_empty;
  assign mem_store_o  = (state_q == ST_STORE);
  assign mem_valid_o  = (state_q == ST_XFER) & ~dat_empty;
  assign mem_hs       = mem_valid_o & mem_ready_i;
  assign last_hs      = mem_hs & mem_last_o;
  assign rsp_push     = (state_q == ST_RESP);

  // count of complete bursts sitting in the data FIFO
  always_ff @(posedge clock) begin
    if (reset) pkt_cnt <= '0;
    else begin
      case ({w_last_hs, last_hs})
        2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (~cmd_empty && pkt_cnt != '0 && ~rsp_full) state_d = ST_STORE;
      ST_STORE: if (mem_accept_i) state_d = ST_XFER;
      ST_XFER:  if (last_hs) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ID (and status) latched at the last beat since the command entry pops then
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_id   <= '0;
      cur_resp <= 2'b00;
`ifdef AXI_WR_PATH_LEN_CHECK_EN
      beat     <= '0;
`endif
    end else begin
`ifdef AXI_WR_PATH_LEN_CHECK_EN
      if (state_q == ST_STORE) beat <= '0;
      else if (mem_hs)         beat <= beat + 9'd1;
      if (last_hs) begin
        cur_id   <= mem_wrid_o;
        cur_resp <= (beat != {1'b0, cmd_len}) ? 2'b10 : 2'b00;
      end
`else
      if (last_hs) begin
        cur_id   <= mem_wrid_o;
        cur_resp <= 2'b00;
      end
`endif
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock)
    if (!reset && aw_hs && axi_awburst_i != 2'b01)
      $fatal(1, "axi_wr_path: unsupported AWBURST %b", axi_awburst_i);
`endif
endmodule
